fib_core: RTL

- Fibonacci generator stage directly downstream of the Wishbone control block.
- Consumes the run enable (switch_out) and the step-rate select (clock_op) from that block.
- Produces the 30-bit Fibonacci value on user IO pads [37:8]; the control block reads these back as buf_io_out[37:8].
- Contains a programmable prescaler, a two-state run FSM, a sequence datapath with overflow wrap, and wrap/step event outputs.

---
 rtl/fib_core_if.sv | 27 ++
 rtl/fib_core.sv | 113 +++++++++++
 2 files changed

// File: rtl/fib_core_if.sv
// Control/status bundle between the Wishbone control block (master) and the
// Fibonacci generator stage (slave).
interface fib_core_if #(
    parameter int CLOCK_WIDTH = 6,
    parameter int OUT_WIDTH   = 30,
    parameter int PADS        = 38
);
    logic                   enable;
    logic [CLOCK_WIDTH-1:0] clock_op;
    logic                   clear_i;
    logic [OUT_WIDTH-1:0]   fib_out;
    logic [PADS-1:0]        io_out;
    logic [PADS-1:0]        io_oeb;
    logic                   step_o;
    logic                   wrap_o;
    logic [7:0]             wrap_count;

    modport master (
        output enable, clock_op, clear_i,
        input  fib_out, io_out, io_oeb, step_o, wrap_o, wrap_count
    );

    modport slave (
        input  enable, clock_op, clear_i,
        output fib_out, io_out, io_oeb, step_o, wrap_o, wrap_count
    );
endinterface

// File: rtl/fib_core.sv
// Fibonacci generator: prescaled run FSM advancing a wrapping 30-bit sequence,
// driving the upper user IO pads and step/wrap event outputs.
module fib_core #(
    parameter int CLOCK_WIDTH = 6,
    parameter int OUT_WIDTH   = 30,
    parameter int PADS        = 38
) (
    input  logic        wb_clk_i,
    input  logic        reset,
    fib_core_if.slave   bus
);
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [CLOCK_WIDTH-1:0] CNT_ONE = {{(CLOCK_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CLOCK_WIDTH-1:0] CNT_ZERO = {CLOCK_WIDTH{1'b0}};
    localparam logic [OUT_WIDTH-1:0]   FIB_ONE = {{(OUT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [OUT_WIDTH-1:0]   FIB_ZERO = {OUT_WIDTH{1'b0}};

    state_t                 state_r, state_s;
    logic [CLOCK_WIDTH-1:0] cnt_r, cnt_s;
    logic [OUT_WIDTH-1:0]   cur_r, cur_s;
    logic [OUT_WIDTH-1:0]   nxt_r, nxt_s;
    logic                   step_r, step_s;
    logic                   wrap_r, wrap_s;
    logic [7:0]             wrap_cnt_r, wrap_cnt_s;
    logic                   tick_s;
    logic [OUT_WIDTH:0]     sum_s;

    // Next-state, prescaler and sequence datapath
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        cur_s      = cur_r;
        nxt_s      = nxt_r;
        step_s     = 1'b0;
        wrap_s     = 1'b0;
        wrap_cnt_s = wrap_cnt_r;
        tick_s     = 1'b0;
        sum_s      = {1'b0, cur_r} + {1'b0, nxt_r};

        if (bus.enable) begin
            state_s = RUN;
        end else begin
            state_s = IDLE;
        end

        // Counting only while running and staying enabled; >= lets a lowered
        // clock_op below the current count fire on the very next edge.
        if ((state_r == RUN) && bus.enable) begin
            if (bus.clock_op == CNT_ZERO) begin
                cnt_s = cnt_r;
            end else if (cnt_r >= (bus.clock_op - CNT_ONE)) begin
                tick_s = 1'b1;
                cnt_s  = CNT_ZERO;
            end else begin
                cnt_s = cnt_r + CNT_ONE;
            end
        end else begin
            cnt_s = CNT_ZERO;
        end

        if (bus.clear_i) begin
            cur_s = FIB_ZERO;
            nxt_s = FIB_ONE;
            cnt_s = CNT_ZERO;
        end else if (tick_s) begin
            step_s = 1'b1;
            if (sum_s[OUT_WIDTH]) begin
                cur_s      = FIB_ZERO;
                nxt_s      = FIB_ONE;
                wrap_s     = 1'b1;
                wrap_cnt_s = wrap_cnt_r + 8'd1;
            end else begin
                cur_s = nxt_r;
                nxt_s = sum_s[OUT_WIDTH-1:0];
            end
        end else begin
            cur_s = cur_r;
            nxt_s = nxt_r;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge wb_clk_i) begin
        if (reset) begin
            state_r    <= IDLE;
            cnt_r      <= CNT_ZERO;
            cur_r      <= FIB_ZERO;
            nxt_r      <= FIB_ONE;
            step_r     <= 1'b0;
            wrap_r     <= 1'b0;
            wrap_cnt_r <= 8'd0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            cur_r      <= cur_s;
            nxt_r      <= nxt_s;
            step_r     <= step_s;
            wrap_r     <= wrap_s;
            wrap_cnt_r <= wrap_cnt_s;
        end
    end

    assign bus.fib_out    = cur_r;
    assign bus.io_out     = {cur_r, {(PADS-OUT_WIDTH){1'b0}}};
    assign bus.io_oeb     = {{OUT_WIDTH{1'b0}}, {(PADS-OUT_WIDTH){1'b1}}};
    assign bus.step_o     = step_r;
    assign bus.wrap_o     = wrap_r;
    assign bus.wrap_count = wrap_cnt_r;
endmodule
